gpio_debounce_bridge: RTL and testbench
=======================================

// Module: gpio_debounce_bridge
//
// PURPOSE
//   Parametrised successor to the three-button-to-LED bridge between the Arduino header and DE1 GPIO.
//   Carries CHANNELS independent input pins to LED outputs.
//   Each channel gets a 2-flop synchroniser and a counter-based debouncer.
//   Each channel also gets one-cycle edge pulses and a per-channel follow/toggle output mode.
//   Sits between the raw GPIO pins and the user logic / LEDs.
//
// PARAMETERS
//   CHANNELS        3     number of pin->LED channels (>=1)
//   DEBOUNCE_CYCLES 16    consecutive differing sample ticks needed to accept a new level (>=1)
//   CNT_W           $clog2(DEBOUNCE_CYCLES+1)   debounce counter width
//   SAMPLE_DIV      1000  clk cycles per sample tick; used only with GPIO_SAMPLE_DIV_EN (>=1)
//
// PORTS
//   clk         in   1         system clock, all logic on posedge
//   rst_n       in   1         asynchronous, active-low reset
//   in_pins     in   CHANNELS  raw asynchronous GPIO inputs
//   mode        in   CHANNELS  per channel: 0 = follow, 1 = toggle (synchronous to clk)
//   out_leds    out  CHANNELS  registered LED drive
//   rise_pulse  out  CHANNELS  1-cycle pulse on accepted 0->1 change
//   fall_pulse  out  CHANNELS  1-cycle pulse on accepted 1->0 change
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): clear to 0 all of: sync flops, stable level, counters, prescaler,
//     out_leds, rise_pulse, fall_pulse. No pulses are emitted on reset release.
//   - Sync: sync1 <= in_pins; sync2 <= sync1. Only sync2 feeds the debouncer.
//   - Sample tick: every clk cycle without the macro.
//   - Debounce, per channel, evaluated on tick cycles:
//       sync2 == stable                  -> cnt <= 0 (glitch abort)
//       sync2 != stable, cnt < D-1       -> cnt <= cnt+1
//       sync2 != stable, cnt == D-1      -> stable <= sync2, cnt <= 0, event
//     In non-tick cycles cnt and stable hold.
//   - Event outputs, registered on the same edge that updates stable:
//       rise_pulse = 1 if new stable is 1; fall_pulse = 1 if new stable is 0.
//       Pulses are high for exactly one clk cycle. Both pulses are never high together.
//   - out_leds: mode=0 -> out <= stable next-state.
//     mode=1 -> out toggles on the rise event only; fall events are ignored.
//   - Mode switch: 1->0 makes out = stable on the next edge. 0->1 holds the current out value.
//   - Latency (tick every cycle): a clean level first sampled at edge 1 reaches stable/out/pulse
//     at edge DEBOUNCE_CYCLES+2.
//   - DEBOUNCE_CYCLES=1: a change is accepted on the first tick after sync2 differs.
//   - Channels are fully independent; simultaneous events on several channels all pulse in the
//     same cycle.
//   - Reset asserted mid-count discards the partial count. Outputs go to 0 immediately.
//
// CONFIGURATION
//   GPIO_SAMPLE_DIV_EN defined:
//     - A shared prescaler counts 0..SAMPLE_DIV-1.
//     - tick = (presc == SAMPLE_DIV-1); the prescaler wraps to 0 on that cycle.
//     - Debounce time becomes DEBOUNCE_CYCLES*SAMPLE_DIV clk cycles.
//     - Pulses stay 1 clk cycle wide.
//   Not defined:
//     - No prescaler logic is generated; tick is tied to 1.
//
// STRUCTURE
//   Package gpio_bridge_pkg:
//     - mode_e typedef (MODE_FOLLOW=1'b0, MODE_TOGGLE=1'b1).
//     - Default constants for CHANNELS and DEBOUNCE_CYCLES.
//   Sub-module gpio_debounce_ch: one channel covering sync, counter, stable, pulses and out.
//     - Top instantiates it CHANNELS times in a generate loop.
//     - Top owns the optional prescaler and fans out tick.
//
// TESTING  (CHANNELS=3, DEBOUNCE_CYCLES=4, macro off unless stated)
//   1. Reset: hold rst_n=0 with in_pins=3'b111 -> out_leds=0 and pulses=0.
//      Release reset -> out_leds=3'b111 at edge 6 after release, with rise_pulse=3'b111 for 1 cycle.
//   2. Glitch: ch0 high for 3 cycles then low -> no rise_pulse[0], out_leds[0] stays 0.
//      A 4-cycle-or-longer high -> accepted.
//   3. Latency: ch1 0->1 held -> rise_pulse[1] exactly at edge 6 after the first sampling edge,
//      1 cycle wide. Release -> fall_pulse[1] 6 edges later.
//   4. Toggle: mode=3'b100, ch2 pressed/released twice -> out_leds[2] goes 1 then 0.
//      Toggles on presses only.
//   5. Simultaneous events and mid-op reset:
//      - All three channels change together -> all pulses are high in the same cycle.
//      - Reset asserted at count=2 -> outputs clear at once; no pulse after release if pins
//        are back to 0.
//   6. GPIO_SAMPLE_DIV_EN with SAMPLE_DIV=5 -> acceptance after 4 ticks (about 20 clk).
//      Pulse stays 1 clk wide.

Source files
------------

// File: rtl/gpio_bridge_pkg.sv
// Shared types and default constants for the GPIO pin-to-LED debounce bridge.
package gpio_bridge_pkg;

    typedef enum logic {
        MODE_FOLLOW = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;

    localparam int unsigned DEF_CHANNELS        = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_SAMPLE_DIV      = 1000;

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO channel: 2-flop synchroniser, tick-gated counter debouncer,
// registered one-cycle edge pulses and a follow/toggle LED output.
module gpio_debounce_ch
    import gpio_bridge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in_pin,
    input  logic mode,
    output logic out_led,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in_pin;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (tick) begin
            if (sync2_q == stable_q) begin
                // Any sample matching the current level aborts a pending change.
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                stable_d = sync2_q;
                cnt_d    = '0;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rise_d = accept & stable_d;
        fall_d = accept & ~stable_d;
        out_d  = out_q;
        unique case (mode_sel)
            MODE_FOLLOW: out_d = stable_d;
            MODE_TOGGLE: out_d = out_q ^ rise_d;
            default:     out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign out_led    = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/gpio_debounce_bridge.sv
// CHANNELS-wide GPIO pin-to-LED bridge with per-channel debounce, edge pulses and modes.
// Optional feature macro: GPIO_SAMPLE_DIV_EN (shared sample-tick prescaler of SAMPLE_DIV clocks).
module gpio_debounce_bridge
    import gpio_bridge_pkg::*;
#(
    parameter int unsigned CHANNELS        = DEF_CHANNELS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int unsigned SAMPLE_DIV      = DEF_SAMPLE_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_pins,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] out_leds,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (SAMPLE_DIV < 1) begin : g_bad_div
        $error("SAMPLE_DIV must be >= 1");
    end

    logic tick;

`ifdef GPIO_SAMPLE_DIV_EN
    localparam int unsigned PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;

    assign tick = (presc_q == PRESC_W'(SAMPLE_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        gpio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .in_pin    (in_pins[i]),
            .mode      (mode[i]),
            .out_led   (out_leds[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce_bridge.sv
// Randomised and directed bench for gpio_debounce_bridge, checked against a
// sliding-window reference model (accept once the last D tick samples all differ).
module tb_gpio_debounce_bridge;

    localparam int CH = 3;
    localparam int D  = 4;
    localparam int SD = 5;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] in_pins;
    logic [CH-1:0] mode;
    logic [CH-1:0] out_leds;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;

    int checks = 0;
    int errors = 0;

    gpio_debounce_bridge #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(D),
        .SAMPLE_DIV     (SD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pins   (in_pins),
        .mode      (mode),
        .out_leds  (out_leds),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inputs reach the debouncer two clocks late; a channel flips once the
    // most recent D tick samples all disagree with its current level.
    logic [CH-1:0] m_d1, m_d2;
    logic [D-1:0]  m_win [CH];
    logic [D-1:0]  m_win_n [CH];
    logic [CH-1:0] m_stable, m_stable_n;
    logic [CH-1:0] m_out, m_out_n;
    logic [CH-1:0] m_rise, m_rise_n;
    logic [CH-1:0] m_fall, m_fall_n;
    int            m_presc, m_presc_n;
    logic          m_tick;

    always_comb begin
`ifdef GPIO_SAMPLE_DIV_EN
        m_tick    = (m_presc == SD - 1);
        m_presc_n = m_tick ? 0 : m_presc + 1;
`else
        m_tick    = 1'b1;
        m_presc_n = 0;
`endif
        m_win_n    = m_win;
        m_stable_n = m_stable;
        m_rise_n   = '0;
        m_fall_n   = '0;
        m_out_n    = m_out;
        for (int c = 0; c < CH; c++) begin
            if (m_tick) begin
                m_win_n[c] = {m_win[c][D-2:0], m_d2[c]};
                if (m_win_n[c] == {D{~m_stable[c]}}) begin
                    m_stable_n[c] = ~m_stable[c];
                    m_rise_n[c]   = ~m_stable[c];
                    m_fall_n[c]   = m_stable[c];
                end
            end
            m_out_n[c] = mode[c] ? (m_out[c] ^ m_rise_n[c]) : m_stable_n[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1     <= '0;
            m_d2     <= '0;
            m_win    <= '{default: '0};
            m_stable <= '0;
            m_out    <= '0;
            m_rise   <= '0;
            m_fall   <= '0;
            m_presc  <= 0;
        end else begin
            m_d1     <= in_pins;
            m_d2     <= m_d1;
            m_win    <= m_win_n;
            m_stable <= m_stable_n;
            m_out    <= m_out_n;
            m_rise   <= m_rise_n;
            m_fall   <= m_fall_n;
            m_presc  <= m_presc_n;
        end
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        in_pins = 3'b111;
        mode    = 3'b000;
        repeat (3) @(negedge clk);
        checks++;
        if (out_leds !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: out=%b rise=%b fall=%b, required all 000",
                     out_leds, rise_pulse, fall_pulse);
        end
        rst_n = 1'b1;
`ifndef GPIO_SAMPLE_DIV_EN
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rise_pulse !== ((k == 6) ? 3'b111 : 3'b000) ||
                out_leds !== ((k >= 6) ? 3'b111 : 3'b000) || fall_pulse !== 3'b000) begin
                errors++;
                $display("FAIL reset_release edge %0d: out=%b rise=%b fall=%b", k, out_leds,
                         rise_pulse, fall_pulse);
            end
        end
`endif
        in_pins = 3'b000;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_glitch();
        int nr;
        int nf;
        nr = 0;
        in_pins[0] = 1'b1;
        repeat (3) @(negedge clk);
        in_pins[0] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nr += int'(rise_pulse[0]);
        end
        checks++;
        if (nr != 0 || out_leds[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_3: rises=%0d out0=%b, required 0 and 0", nr, out_leds[0]);
        end
        nr = 0;
        nf = 0;
        in_pins[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            nr += int'(rise_pulse[0]);
        end
        in_pins[0] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nr += int'(rise_pulse[0]);
            nf += int'(fall_pulse[0]);
        end
        checks++;
        if (nr != 1 || nf != 1 || out_leds[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_4: rises=%0d falls=%0d out0=%b, required 1 1 0", nr, nf,
                     out_leds[0]);
        end
    endtask

    task automatic test_latency();
        in_pins[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rise_pulse[1] !== (k == 6) || out_leds[1] !== (k >= 6)) begin
                errors++;
                $display("FAIL latency_rise edge %0d: rise1=%b out1=%b", k, rise_pulse[1],
                         out_leds[1]);
            end
        end
        in_pins[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (fall_pulse[1] !== (k == 6) || rise_pulse[1] !== 1'b0 ||
                out_leds[1] !== (k < 6)) begin
                errors++;
                $display("FAIL latency_fall edge %0d: fall1=%b rise1=%b out1=%b", k,
                         fall_pulse[1], rise_pulse[1], out_leds[1]);
            end
        end
    endtask

    task automatic test_toggle();
        logic exp_out [4];
        exp_out = '{1'b1, 1'b1, 1'b0, 1'b0};
        mode = 3'b100;
        for (int p = 0; p < 4; p++) begin
            in_pins[2] = (p % 2 == 0);
            repeat (10) @(negedge clk);
            checks++;
            if (out_leds[2] !== exp_out[p]) begin
                errors++;
                $display("FAIL toggle step %0d: out2=%b required %b", p, out_leds[2],
                         exp_out[p]);
            end
        end
        // Leave the LED on with the pin released, then drop back to follow mode.
        in_pins[2] = 1'b1;
        repeat (10) @(negedge clk);
        in_pins[2] = 1'b0;
        repeat (10) @(negedge clk);
        mode = 3'b000;
        @(negedge clk);
        checks++;
        if (out_leds[2] !== 1'b0) begin
            errors++;
            $display("FAIL toggle_to_follow: out2=%b required 0", out_leds[2]);
        end
    endtask

    task automatic test_simultaneous();
        in_pins = 3'b111;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rise_pulse !== ((k == 6) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: rise=%b", k, rise_pulse);
            end
        end
        in_pins = 3'b000;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_leds !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000) begin
            errors++;
            $display("FAIL midcount_reset: out=%b rise=%b fall=%b, required 000", out_leds,
                     rise_pulse, fall_pulse);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rise_pulse !== 3'b000 || fall_pulse !== 3'b000 || out_leds !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_quiet cycle %0d: out=%b rise=%b fall=%b", k,
                         out_leds, rise_pulse, fall_pulse);
            end
        end
    endtask

`ifdef GPIO_SAMPLE_DIV_EN
    task automatic test_sample_div();
        int first;
        first = -1;
        in_pins = 3'b001;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (first < 0 && rise_pulse[0] === 1'b1) first = k;
            else if (first >= 0 && k == first + 1) begin
                checks++;
                if (rise_pulse[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL sample_div_width: rise0=%b required 0", rise_pulse[0]);
                end
            end
        end
        checks++;
        if (first < 15 || first > 25) begin
            errors++;
            $display("FAIL sample_div_latency: edge %0d required 15..25", first);
        end
        in_pins = 3'b000;
        repeat (40) @(negedge clk);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            checks++;
            if (out_leds !== m_out || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                (rise_pulse & fall_pulse) !== 3'b000) begin
                errors++;
                $display("FAIL random cycle %0d: out=%b rise=%b fall=%b, required %b %b %b",
                         k, out_leds, rise_pulse, fall_pulse, m_out, m_rise, m_fall);
            end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(3) == 0) in_pins[c] = ~in_pins[c];
            end
            if ($urandom_range(31) == 0) mode = 3'($urandom_range(7));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_pins = '0;
        mode    = '0;
        test_reset();
`ifdef GPIO_SAMPLE_DIV_EN
        test_sample_div();
`else
        test_glitch();
        test_latency();
        test_toggle();
        test_simultaneous();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
